// File: rtl/writeback_regfile_pkg.sv
// Shared register-index constants and the writeback destination rule.
// Imported by writeback, decode and hazard logic.
package writeback_regfile_pkg;

    localparam int REG_IDX_W = 4;

    localparam logic [REG_IDX_W-1:0] LR_IDX = 4'd14;
    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    localparam int unsigned PC_READ_OFFSET_DEF = 8;

    // Link writebacks always land in R14, whatever rd says.
    function automatic logic [REG_IDX_W-1:0] wb_dest(
        input logic                 link,
        input logic [REG_IDX_W-1:0] rd
    );
        return link ? LR_IDX : rd;
    endfunction

endpackage

// File: rtl/regfile_bank_15x32.sv
// Storage for R0..R14: one synchronous write port, two async read ports.
// Ports: clk, reset, we/waddr/wdata write, raddr_a/b -> rdata_a/b reads.
module regfile_bank_15x32
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] regs [0:14];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != PC_IDX) begin
            regs[waddr] <= wdata;
        end
    end

    // Index 15 has no storage; the top substitutes the PC for it.
    assign rdata_a = (raddr_a == PC_IDX) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == PC_IDX) ? '0 : regs[raddr_b];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits MEM/WB results, serves decode reads, R15 redirect.
// Ports: wb_* writeback in, pc_in, rn/rm read ports, redirect_*, wb_count.
// Build option: define WB_BYPASS_EN for same-cycle write-to-read forwarding.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int unsigned PC_READ_OFFSET = PC_READ_OFFSET_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    wb_data_in,
    input  logic [REG_IDX_W-1:0] wb_rd_in,
    input  logic                 wb_link_in,
    input  logic                 wb_en_in,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic [REG_IDX_W-1:0] rn_addr,
    input  logic [REG_IDX_W-1:0] rm_addr,
    output logic [DATA_W-1:0]    rn_data,
    output logic [DATA_W-1:0]    rm_data,
    output logic                 redirect_valid,
    output logic [DATA_W-1:0]    redirect_target,
    output logic [31:0]          wb_count
);

    logic [REG_IDX_W-1:0] dest;
    logic                 pc_write;
    logic                 reg_write;
    logic [DATA_W-1:0]    bank_a;
    logic [DATA_W-1:0]    bank_b;
    logic [DATA_W-1:0]    pc_read;
    logic                 valid;
    logic [DATA_W-1:0]    target;
    logic [31:0]          count;

    assign dest      = wb_dest(wb_link_in, wb_rd_in);
    assign pc_write  = wb_en_in && dest == PC_IDX;
    assign reg_write = wb_en_in && dest != PC_IDX;
    assign pc_read   = pc_in + DATA_W'(PC_READ_OFFSET);

    regfile_bank_15x32 #(
        .DATA_W (DATA_W)
    ) bank (
        .clk     (clk),
        .reset   (reset),
        .we      (reg_write),
        .waddr   (dest),
        .wdata   (wb_data_in),
        .raddr_a (rn_addr),
        .raddr_b (rm_addr),
        .rdata_a (bank_a),
        .rdata_b (bank_b)
    );

    always_comb begin
        rn_data = bank_a;
        rm_data = bank_b;
`ifdef WB_BYPASS_EN
        // reg_write already excludes R15, so the PC path is never bypassed.
        if (reg_write && dest == rn_addr) rn_data = wb_data_in;
        if (reg_write && dest == rm_addr) rm_data = wb_data_in;
`endif
        if (rn_addr == PC_IDX) rn_data = pc_read;
        if (rm_addr == PC_IDX) rm_data = pc_read;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            target <= '0;
            count  <= '0;
        end else begin
            valid <= pc_write;
            if (pc_write) target <= wb_data_in;
            if (wb_en_in) count <= count + 32'd1;
        end
    end

    assign redirect_valid  = valid;
    assign redirect_target = target;
    assign wb_count        = count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: directed plan plus random traffic.
// Honours WB_BYPASS_EN in its reference model.
module tb_writeback_regfile;

    logic        clk = 0;
    logic        reset;
    logic [31:0] wb_data_in;
    logic [3:0]  wb_rd_in;
    logic        wb_link_in;
    logic        wb_en_in;
    logic [31:0] pc_in;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] wb_count;

    writeback_regfile dut (
        .clk             (clk),
        .reset           (reset),
        .wb_data_in      (wb_data_in),
        .wb_rd_in        (wb_rd_in),
        .wb_link_in      (wb_link_in),
        .wb_en_in        (wb_en_in),
        .pc_in           (pc_in),
        .rn_addr         (rn_addr),
        .rm_addr         (rm_addr),
        .rn_data         (rn_data),
        .rm_data         (rm_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .wb_count        (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rn;
        logic [31:0] rm;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb [$];
    int          passed = 0;
    int          total  = 0;
    bit          done   = 0;

    // Reference architectural state.
    logic [31:0] m_reg [0:14];
    logic        m_rv;
    logic [31:0] m_rt;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int d;
        if (a == 15) return pc_in + 32'd8;
        d = wb_link_in ? 14 : int'(wb_rd_in);
`ifdef WB_BYPASS_EN
        if (!reset && wb_en_in && d != 15 && d == int'(a)) return wb_data_in;
`endif
        return m_reg[a];
    endfunction

    // Drive one cycle's inputs, push this cycle's expectation, then
    // advance the model across the upcoming rising edge.
    task automatic step(input logic rst, input logic en, input logic lnk,
                        input logic [3:0] rd, input logic [31:0] data,
                        input logic [31:0] pc, input logic [3:0] a,
                        input logic [3:0] b);
        exp_t e;
        int   d;
        reset = rst; wb_en_in = en; wb_link_in = lnk; wb_rd_in = rd;
        wb_data_in = data; pc_in = pc; rn_addr = a; rm_addr = b;
        e.rn = m_read(a);
        e.rm = m_read(b);
        e.rv = m_rv;
        e.rt = m_rt;
        e.cnt = m_cnt;
        sb.push_back(e);
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_rv = 0; m_rt = 0; m_cnt = 0;
        end else begin
            d = lnk ? 14 : int'(rd);
            m_rv = en && d == 15;
            if (m_rv) m_rt = data;
            if (en) begin
                if (d != 15) m_reg[d] = data;
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            chk("rn_data", rn_data, e.rn);
            chk("rm_data", rm_data, e.rm);
            chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            if (e.rv) chk("redirect_target", redirect_target, e.rt);
            chk("wb_count", wb_count, e.cnt);
        end
    end

    initial begin : driver
        foreach (m_reg[i]) m_reg[i] = 0;
        m_rv = 0; m_rt = 0; m_cnt = 0;
        reset = 1; wb_en_in = 0; wb_link_in = 0; wb_rd_in = 0;
        wb_data_in = 0; pc_in = 0; rn_addr = 0; rm_addr = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 32'h100, 0, 15);
        for (int i = 0; i < 16; i += 2) begin
            @(negedge clk);
            step(0, 0, 0, 0, 0, 32'h100, 4'(i), 4'(i + 1));
        end
        @(negedge clk); step(0, 1, 0, 3, 32'hDEADBEEF, 32'h100, 3, 15);
        @(negedge clk); step(0, 1, 1, 7, 32'h2004, 32'h100, 3, 14);
        @(negedge clk); step(0, 1, 0, 15, 32'h4000, 32'h100, 14, 7);
        @(negedge clk); step(0, 0, 1, 14, 32'hFFFF, 32'h200, 15, 14);
        @(negedge clk); step(0, 0, 0, 0, 0, 32'h200, 14, 15);
        @(negedge clk); step(0, 1, 0, 15, 32'h10, 32'h0, 0, 0);
        @(negedge clk); step(0, 1, 0, 15, 32'h20, 32'h0, 0, 0);
        @(negedge clk); step(0, 1, 1, 15, 32'h30, 32'hFFFFFFFC, 14, 15);
        @(negedge clk); step(0, 0, 0, 0, 0, 32'h0, 14, 15);
        @(negedge clk); step(1, 1, 0, 15, 32'h5555, 32'h100, 14, 3);
        @(negedge clk); step(0, 0, 0, 0, 0, 32'h100, 14, 3);
        @(negedge clk);
        dut.count = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        step(0, 1, 0, 5, 32'h1234, 32'h100, 5, 5);
        @(negedge clk); step(0, 0, 0, 0, 0, 32'h100, 5, 5);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom,
                 $urandom,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end
        @(negedge clk); step(0, 0, 0, 0, 0, 32'h0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        done = 1;
        #3;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
